hazard_scoreboard: RTL

Parametrised scoreboard hazard unit for the pipelined ARM core, generalising the fixed match-based hazard logic to variable-latency producers (loads, MUL, long MUL/MLA). Tracks a per-register countdown of cycles until each in-flight result becomes forwardable, and stalls Decode on RAW/WAW conflicts. Supports up to three source and two destination registers per instruction. Sits beside the controller and datapath and feeds StallF/StallD.

---
 rtl/hazard_scoreboard_if.sv | 43 ++++
 rtl/hazard_scoreboard.sv | 96 +++++++++
 2 files changed

// File: rtl/hazard_scoreboard_if.sv
// Decode-stage issue bundle and hazard/status outputs of the hazard scoreboard.
// The slave modport is the scoreboard; the master modport is the controller side.
interface hazard_scoreboard_if #(
    parameter int NREGS = 16,
    parameter int AW    = 4,
    parameter int CW    = 3,
    parameter int PW    = 16
);
    logic             IssueD;
    logic             FlushD;
    logic             FlushAll;
    logic [AW-1:0]    RA1D;
    logic [AW-1:0]    RA2D;
    logic [AW-1:0]    RA3D;
    logic             UseRA1D;
    logic             UseRA2D;
    logic             UseRA3D;
    logic [AW-1:0]    WA3D;
    logic [AW-1:0]    WA4D;
    logic             WrA3D;
    logic             WrA4D;
    logic [CW-1:0]    LatD;
    logic             StallF;
    logic             StallD;
    logic [NREGS-1:0] BusyVec;
    logic [AW:0]      PendingCnt;
    logic [PW-1:0]    StallCycles;
    logic             ConflictErr;

    modport master (
        output IssueD, FlushD, FlushAll,
        output RA1D, RA2D, RA3D, UseRA1D, UseRA2D, UseRA3D,
        output WA3D, WA4D, WrA3D, WrA4D, LatD,
        input  StallF, StallD, BusyVec, PendingCnt, StallCycles, ConflictErr
    );

    modport slave (
        input  IssueD, FlushD, FlushAll,
        input  RA1D, RA2D, RA3D, UseRA1D, UseRA2D, UseRA3D,
        input  WA3D, WA4D, WrA3D, WrA4D, LatD,
        output StallF, StallD, BusyVec, PendingCnt, StallCycles, ConflictErr
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard: cnt[r] is the number of cycles until the
// in-flight result for r is forwardable. Stalls Decode on RAW/WAW conflicts.
module hazard_scoreboard #(
    parameter int NREGS   = 16,
    parameter int AW      = 4,
    parameter int CW      = 3,
    parameter int LAT_MAX = 6,
    parameter int PW      = 16
) (
    input logic                 clk,
    input logic                 reset,
    hazard_scoreboard_if.slave  bus
);

    logic [CW-1:0]    cnt [NREGS];
    logic [CW-1:0]    leff;
    logic             raw_hit;
    logic             waw_hit;
    logic             req;
    logic             stall;
    logic             fire;
    logic             same_dest;
    logic [NREGS-1:0] busy;
    logic [AW:0]      pend;

    assign leff = (bus.LatD > CW'(LAT_MAX)) ? CW'(LAT_MAX) : bus.LatD;

    // cnt == 1 means the value is on the forwarding path next cycle, so only > 1 stalls.
    assign raw_hit = (bus.UseRA1D && (cnt[bus.RA1D] > CW'(1)))
                   || (bus.UseRA2D && (cnt[bus.RA2D] > CW'(1)))
                   || (bus.UseRA3D && (cnt[bus.RA3D] > CW'(1)));

    // An older write still landing after this one would leave the wrong final value.
    assign waw_hit = (bus.WrA3D && (cnt[bus.WA3D] > leff))
                   || (bus.WrA4D && (cnt[bus.WA4D] > leff));

    assign req       = bus.IssueD && !bus.FlushD && !bus.FlushAll;
    assign stall     = req && (raw_hit || waw_hit);
    assign fire      = req && !stall;
    assign same_dest = bus.WrA3D && bus.WrA4D && (bus.WA3D == bus.WA4D);

    // NOTE: every bit written in always_comb gets a value before any loop or
    // branch, otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        busy = '0;
        pend = '0;
        for (int r = 0; r < NREGS; r++) begin
            busy[r] = (cnt[r] != '0);
            pend    = pend + (AW+1)'(busy[r]);
        end
    end

    // NOTE: the counter array is cleared by reset on purpose: it is control
    // state, and a stale count would stall or mis-forward after reset.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NREGS; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                if (bus.FlushAll) begin
                    cnt[r] <= '0;
                end else if (fire && (leff != '0) &&
                             ((bus.WrA3D && (bus.WA3D == AW'(r))) ||
                              (bus.WrA4D && (bus.WA4D == AW'(r))))) begin
                    cnt[r] <= leff;
                end else if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.StallCycles <= '0;
            bus.ConflictErr <= 1'b0;
        end else begin
            if (stall && (bus.StallCycles != '1)) begin
                bus.StallCycles <= bus.StallCycles + PW'(1);
            end
            if (fire && same_dest) begin
                bus.ConflictErr <= 1'b1;
            end
        end
    end

    assign bus.StallD     = stall;
    assign bus.StallF     = stall;
    assign bus.BusyVec    = busy;
    assign bus.PendingCnt = pend;

endmodule
